// File: rtl/cache_line_mover.sv
// cache_line_mover: victim write-back and line fill engine wrapped around cache_data.
// Optional macro CACHE_LINE_MOVER_FWD_EN adds per-beat fill forwarding outputs.
module cache_line_mover #(
  parameter int ADDR_W    = 25,
  parameter int WB_ALWAYS = 0
) (
  input  logic              main_clk,
  input  logic              main_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [10:0]       req_segment,
  input  logic [1:0]        req_way,
  input  logic [ADDR_W-1:0] req_evict_addr,
  input  logic [ADDR_W-1:0] req_fill_addr,
  output logic              done,
`ifdef CACHE_LINE_MOVER_FWD_EN
  output logic              fwd_valid,
  output logic [2:0]        fwd_index,
  output logic [15:0]       fwd_data,
`endif
  output logic [10:0]       cd_target_segment,
  output logic [1:0]        cd_target_way,
  output logic              cd_do_full_write,
  output logic [127:0]      cd_raw_in,
  input  logic [127:0]      cd_raw_out,
  input  logic              cd_dirty,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_write,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rdata_valid
);

  typedef enum logic [2:0] {
    IDLE, RD0, RD1, WB_CMD, WB_DATA, FILL_CMD, FILL_DATA, COMMIT
  } state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] evict_addr, fill_addr;
  logic [127:0]      line_buf;
  logic [2:0]        cnt;

  always_ff @(posedge main_clk or posedge main_rst) begin
    if (main_rst) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state       = state;
    req_ready        = 1'b0;
    done             = 1'b0;
    cd_do_full_write = 1'b0;
    mem_cmd_valid    = 1'b0;
    mem_cmd_write    = 1'b0;
    mem_cmd_addr     = '0;
    mem_wdata_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = RD0;
      end
      RD0: next_state = RD1;
      RD1: next_state = (cd_dirty || (WB_ALWAYS != 0)) ? WB_CMD : FILL_CMD;
      WB_CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_write = 1'b1;
        mem_cmd_addr  = evict_addr;
        if (mem_cmd_ready) next_state = WB_DATA;
      end
      WB_DATA: begin
        mem_wdata_valid = 1'b1;
        if (mem_wdata_ready && cnt == 3'd7) next_state = FILL_CMD;
      end
      FILL_CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_addr  = fill_addr;
        if (mem_cmd_ready) next_state = FILL_DATA;
      end
      FILL_DATA: begin
        // Counter wrapping past 7 is the completion point; no ninth beat is taken.
        if (mem_rdata_valid && cnt == 3'd7) next_state = COMMIT;
      end
      COMMIT: begin
        done             = 1'b1;
        cd_do_full_write = 1'b1;
        next_state       = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge main_clk or posedge main_rst) begin
    if (main_rst) begin
      cd_target_segment <= '0;
      cd_target_way     <= '0;
      evict_addr        <= '0;
      fill_addr         <= '0;
      line_buf          <= '0;
      cnt               <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cd_target_segment <= req_segment;
          cd_target_way     <= req_way;
          evict_addr        <= req_evict_addr;
          fill_addr         <= req_fill_addr;
        end
        RD1:               line_buf <= cd_raw_out;
        WB_CMD, FILL_CMD:  cnt <= '0;
        WB_DATA:           if (mem_wdata_ready) cnt <= cnt + 3'd1;
        FILL_DATA: if (mem_rdata_valid) begin
          line_buf[{cnt, 4'b0000} +: 16] <= mem_rdata;
          cnt                            <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign cd_raw_in = line_buf;
  assign mem_wdata = line_buf[{cnt, 4'b0000} +: 16];

`ifdef CACHE_LINE_MOVER_FWD_EN
  assign fwd_valid = (state == FILL_DATA) && mem_rdata_valid;
  assign fwd_index = cnt;
  assign fwd_data  = mem_rdata;
`endif

endmodule

// File: tb/tb_cache_line_mover.sv
// Scoreboard bench for cache_line_mover: a memory responder pops expected commands,
// write beats and committed lines that each scenario task pushes when it issues a request.
module tb_cache_line_mover;
  localparam int ADDR_W = 25;

  logic              main_clk = 1'b0;
  logic              main_rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [10:0]       req_segment = '0;
  logic [1:0]        req_way = '0;
  logic [ADDR_W-1:0] req_evict_addr = '0;
  logic [ADDR_W-1:0] req_fill_addr = '0;
  logic              done;
  logic [10:0]       cd_target_segment;
  logic [1:0]        cd_target_way;
  logic              cd_do_full_write;
  logic [127:0]      cd_raw_in;
  logic [127:0]      cd_raw_out = '0;
  logic              cd_dirty = 1'b0;
  logic              mem_cmd_valid;
  logic              mem_cmd_ready = 1'b0;
  logic              mem_cmd_write;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [15:0]       mem_wdata;
  logic              mem_wdata_valid;
  logic              mem_wdata_ready = 1'b0;
  logic [15:0]       mem_rdata = '0;
  logic              mem_rdata_valid = 1'b0;
`ifdef CACHE_LINE_MOVER_FWD_EN
  logic              fwd_valid;
  logic [2:0]        fwd_index;
  logic [15:0]       fwd_data;
`endif

  always #5 main_clk = ~main_clk;

  cache_line_mover #(.ADDR_W(ADDR_W), .WB_ALWAYS(0)) dut (
    .main_clk(main_clk), .main_rst(main_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_segment(req_segment), .req_way(req_way),
    .req_evict_addr(req_evict_addr), .req_fill_addr(req_fill_addr),
    .done(done),
`ifdef CACHE_LINE_MOVER_FWD_EN
    .fwd_valid(fwd_valid), .fwd_index(fwd_index), .fwd_data(fwd_data),
`endif
    .cd_target_segment(cd_target_segment), .cd_target_way(cd_target_way),
    .cd_do_full_write(cd_do_full_write), .cd_raw_in(cd_raw_in),
    .cd_raw_out(cd_raw_out), .cd_dirty(cd_dirty),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr),
    .mem_wdata(mem_wdata), .mem_wdata_valid(mem_wdata_valid),
    .mem_wdata_ready(mem_wdata_ready),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
  );

  int total = 0;
  int bad = 0;

  logic [ADDR_W:0] cmd_q[$];
  logic [15:0]     wbeat_q[$];
  logic [15:0]     fill_q[$];
  logic [127:0]    commit_q[$];
  logic [10:0]     exp_seg = '0;
  logic [1:0]      exp_way = '0;

  int cmd_stall = 0;
  bit wtoggle = 1'b0;
  bit rgap = 1'b0;
  int stray_req = 0;
  int stray_done = 0;
  int wbeats_done = 0;
  int fwd_pulses = 0;

  // Memory responder and scoreboard: decides ready/valid at negedge, so a handshake
  // decided here completes on the following posedge.
  int              cmd_wait = 0;
  int              rd_left = 0;
  bit              wtog = 1'b0;
  bit              rphase = 1'b0;
  bit              wstall_prev = 1'b0;
  bit              cstall_prev = 1'b0;
  logic [15:0]     wprev = '0;
  logic [ADDR_W:0] cprev = '0;
  logic [ADDR_W:0] cexp;
  logic [15:0]     wexp;
  logic [127:0]    lexp;

  always @(negedge main_clk) begin
    if (main_rst) begin
      mem_cmd_ready   = 1'b0;
      mem_wdata_ready = 1'b0;
      mem_rdata_valid = 1'b0;
      cmd_wait = 0; rd_left = 0; rphase = 1'b0; wtog = 1'b0;
      wstall_prev = 1'b0; cstall_prev = 1'b0;
    end else begin
      mem_rdata_valid = 1'b0;
      if (rd_left > 0) begin
        rphase = ~rphase;
        if (!rgap || rphase) begin
          mem_rdata_valid = 1'b1;
          mem_rdata = (fill_q.size() > 0) ? fill_q.pop_front() : 16'hDEAD;
          rd_left--;
        end
      end else if (stray_req != stray_done && req_ready === 1'b1) begin
        mem_rdata_valid = 1'b1;
        mem_rdata = 16'hBAD0;
        stray_done++;
      end

      mem_cmd_ready = 1'b0;
      if (mem_cmd_valid === 1'b1) begin
        if (cstall_prev) begin
          total++;
          if ({mem_cmd_write, mem_cmd_addr} !== cprev) begin
            bad++;
            $display("FAIL cmd_stable got=%h want=%h", {mem_cmd_write, mem_cmd_addr}, cprev);
          end
        end
        if (cmd_wait < cmd_stall) begin
          cmd_wait++;
          cstall_prev = 1'b1;
          cprev = {mem_cmd_write, mem_cmd_addr};
        end else begin
          mem_cmd_ready = 1'b1;
          cmd_wait = 0;
          cstall_prev = 1'b0;
          total++;
          if (cmd_q.size() == 0) begin
            bad++;
            $display("FAIL cmd_unexpected got=%h want=none", {mem_cmd_write, mem_cmd_addr});
          end else begin
            cexp = cmd_q.pop_front();
            if ({mem_cmd_write, mem_cmd_addr} !== cexp) begin
              bad++;
              $display("FAIL cmd got=%h want=%h", {mem_cmd_write, mem_cmd_addr}, cexp);
            end
          end
          total++;
          if (cd_target_segment !== exp_seg || cd_target_way !== exp_way) begin
            bad++;
            $display("FAIL target_at_cmd got=%h/%0d want=%h/%0d",
                     cd_target_segment, cd_target_way, exp_seg, exp_way);
          end
          if (mem_cmd_write === 1'b0) rd_left = 8;
        end
      end else begin
        cstall_prev = 1'b0;
      end

      mem_wdata_ready = 1'b0;
      if (mem_wdata_valid === 1'b1) begin
        if (wstall_prev) begin
          total++;
          if (mem_wdata !== wprev) begin
            bad++;
            $display("FAIL wdata_stable got=%h want=%h", mem_wdata, wprev);
          end
        end
        wtog = ~wtog;
        if (!wtoggle || wtog) begin
          mem_wdata_ready = 1'b1;
          wstall_prev = 1'b0;
          wbeats_done++;
          total++;
          if (wbeat_q.size() == 0) begin
            bad++;
            $display("FAIL wbeat_unexpected got=%h want=none", mem_wdata);
          end else begin
            wexp = wbeat_q.pop_front();
            if (mem_wdata !== wexp) begin
              bad++;
              $display("FAIL wbeat got=%h want=%h", mem_wdata, wexp);
            end
          end
        end else begin
          wstall_prev = 1'b1;
          wprev = mem_wdata;
        end
      end else begin
        wstall_prev = 1'b0;
      end

      if (cd_do_full_write === 1'b1) begin
        total++;
        if (done !== 1'b1) begin
          bad++;
          $display("FAIL done_with_commit got=%b want=1", done);
        end
        total++;
        if (commit_q.size() == 0) begin
          bad++;
          $display("FAIL commit_unexpected got=%h want=none", cd_raw_in);
        end else begin
          lexp = commit_q.pop_front();
          if (cd_raw_in !== lexp) begin
            bad++;
            $display("FAIL commit_line got=%h want=%h", cd_raw_in, lexp);
          end
        end
        total++;
        if (cd_target_segment !== exp_seg || cd_target_way !== exp_way) begin
          bad++;
          $display("FAIL target_at_commit got=%h/%0d want=%h/%0d",
                   cd_target_segment, cd_target_way, exp_seg, exp_way);
        end
      end else if (done !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL done_without_commit got=%b want=0", done);
      end
    end
  end

`ifdef CACHE_LINE_MOVER_FWD_EN
  int fwd_exp_idx = 0;
  always @(negedge main_clk) begin
    #1;
    if (main_rst) begin
      fwd_exp_idx = 0;
    end else if (fwd_valid === 1'b1) begin
      fwd_pulses++;
      total++;
      if (fwd_index !== 3'(fwd_exp_idx) || fwd_data !== mem_rdata) begin
        bad++;
        $display("FAIL fwd got=%0d/%h want=%0d/%h", fwd_index, fwd_data, fwd_exp_idx, mem_rdata);
      end
      fwd_exp_idx = (fwd_exp_idx + 1) % 8;
    end
  end
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after acceptance.
  task automatic issue_req(input logic [10:0] seg, input logic [1:0] way,
                           input logic [ADDR_W-1:0] ev, input logic [ADDR_W-1:0] fa,
                           input logic [127:0] victim, input bit dirty, input logic [15:0] base);
    logic [127:0] line;
    exp_seg = seg;
    exp_way = way;
    cd_raw_out = victim;
    cd_dirty = dirty;
    if (dirty) begin
      cmd_q.push_back({1'b1, ev});
      for (int i = 0; i < 8; i++) wbeat_q.push_back(victim[i*16 +: 16]);
    end
    cmd_q.push_back({1'b0, fa});
    line = '0;
    for (int i = 0; i < 8; i++) begin
      line[i*16 +: 16] = base + 16'(i);
      fill_q.push_back(base + 16'(i));
    end
    commit_q.push_back(line);
    req_segment = seg;
    req_way = way;
    req_evict_addr = ev;
    req_fill_addr = fa;
    req_valid = 1'b1;
    @(posedge main_clk); #1;
    req_valid = 1'b0;
    req_segment = '0;
    req_way = '0;
  endtask

  task automatic wait_done(output int cycles, output bit busy_ok);
    cycles = 0;
    busy_ok = 1'b1;
    while (cycles < 300) begin
      if (done === 1'b1) break;
      if (req_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge main_clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    main_rst = 1'b1;
    repeat (3) @(posedge main_clk);
    #1;
    total++;
    if (req_ready !== 1'b1 || done !== 1'b0 || cd_do_full_write !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b%b%b want=100", req_ready, done, cd_do_full_write);
    end
    total++;
    if (mem_cmd_valid !== 1'b0 || mem_wdata_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mem got=%b%b want=00", mem_cmd_valid, mem_wdata_valid);
    end
    total++;
    if (cd_raw_in !== '0 || cd_target_segment !== '0 || cd_target_way !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%0d want=0/0/0", cd_raw_in, cd_target_segment, cd_target_way);
    end
    main_rst = 1'b0;
    @(posedge main_clk); #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b want=1", req_ready);
    end
  endtask

  task automatic check_complete(input string name, input int cycles);
    total++;
    if (cycles >= 300) begin
      bad++;
      $display("FAIL %s_timeout got=%0d want<300", name, cycles);
    end
    @(posedge main_clk); #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_after got=%b want=1", name, req_ready);
    end
    total++;
    if (cmd_q.size() != 0 || wbeat_q.size() != 0 || commit_q.size() != 0 || fill_q.size() != 0) begin
      bad++;
      $display("FAIL %s_leftover got=%0d/%0d/%0d/%0d want=0/0/0/0", name,
               cmd_q.size(), wbeat_q.size(), commit_q.size(), fill_q.size());
    end
  endtask

  task automatic test_clean;
    int cyc;
    bit busy;
    issue_req(11'h123, 2'd2, 25'h0000055, 25'h00000A0,
              {$urandom, $urandom, $urandom, $urandom}, 1'b0, 16'h1000);
    wait_done(cyc, busy);
    total++;
    if (!busy) begin
      bad++;
      $display("FAIL clean_busy_ready got=1 want=0");
    end
    check_complete("clean", cyc);
  endtask

  task automatic test_dirty;
    int cyc;
    bit busy;
    int w0;
    w0 = wbeats_done;
    issue_req(11'h3A5, 2'd1, 25'h000001F, 25'h0000200,
              128'hFFFF_EEEE_DDDD_CCCC_3333_2222_1111_0000, 1'b1, 16'h2000);
    wait_done(cyc, busy);
    total++;
    if (wbeats_done - w0 != 8) begin
      bad++;
      $display("FAIL dirty_beats got=%0d want=8", wbeats_done - w0);
    end
    check_complete("dirty", cyc);
  endtask

  task automatic test_backpressure;
    int cyc;
    bit busy;
    int w0;
    cmd_stall = 3;
    wtoggle = 1'b1;
    w0 = wbeats_done;
    issue_req(11'h7FF, 2'd3, 25'h1ABCDEF, 25'h0123456,
              {$urandom, $urandom, $urandom, $urandom}, 1'b1, 16'h3000);
    wait_done(cyc, busy);
    total++;
    if (wbeats_done - w0 != 8) begin
      bad++;
      $display("FAIL bp_beats got=%0d want=8", wbeats_done - w0);
    end
    check_complete("bp", cyc);
    cmd_stall = 0;
    wtoggle = 1'b0;
  endtask

  task automatic test_gapped_fill;
    int cyc;
    bit busy;
    rgap = 1'b1;
    stray_req++;
    repeat (3) @(posedge main_clk);
    #1;
    total++;
    if (stray_done != stray_req) begin
      bad++;
      $display("FAIL stray_sent got=%0d want=%0d", stray_done, stray_req);
    end
    issue_req(11'h040, 2'd0, 25'h0000011, 25'h0000F00,
              {$urandom, $urandom, $urandom, $urandom}, 1'b0, 16'hC0DE);
    wait_done(cyc, busy);
    total++;
    if (!busy) begin
      bad++;
      $display("FAIL gap_busy_ready got=1 want=0");
    end
    check_complete("gap", cyc);
    rgap = 1'b0;
  endtask

  task automatic test_reset_mid_wb;
    int cyc;
    bit busy;
    int w0;
    int n;
    w0 = wbeats_done;
    issue_req(11'h2B2, 2'd2, 25'h0000777, 25'h0000888,
              {$urandom, $urandom, $urandom, $urandom}, 1'b1, 16'h4000);
    n = 0;
    while (wbeats_done < w0 + 4 && n < 100) begin
      @(posedge main_clk); #1;
      n++;
    end
    total++;
    if (wbeats_done != w0 + 4) begin
      bad++;
      $display("FAIL midrst_reach got=%0d want=4", wbeats_done - w0);
    end
    main_rst = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1 || done !== 1'b0 || cd_do_full_write !== 1'b0 ||
        mem_cmd_valid !== 1'b0 || mem_wdata_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_ctrl got=%b%b%b%b%b want=10000", req_ready, done,
               cd_do_full_write, mem_cmd_valid, mem_wdata_valid);
    end
    total++;
    if (cd_raw_in !== '0 || cd_target_segment !== '0 || cd_target_way !== '0) begin
      bad++;
      $display("FAIL midrst_data got=%h/%h/%0d want=0/0/0", cd_raw_in, cd_target_segment, cd_target_way);
    end
    cmd_q.delete();
    wbeat_q.delete();
    fill_q.delete();
    commit_q.delete();
    @(posedge main_clk); #1;
    main_rst = 1'b0;
    @(posedge main_clk); #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_ready_after got=%b want=1", req_ready);
    end
    issue_req(11'h155, 2'd1, 25'h0000999, 25'h0000AAA,
              {$urandom, $urandom, $urandom, $urandom}, 1'b1, 16'h5000);
    wait_done(cyc, busy);
    check_complete("after_rst", cyc);
  endtask

  task automatic test_forward;
    int cyc;
    bit busy;
    int p0;
    p0 = fwd_pulses;
    issue_req(11'h00F, 2'd3, 25'h0000001, 25'h0000002,
              {$urandom, $urandom, $urandom, $urandom}, 1'b0, 16'h6000);
    wait_done(cyc, busy);
    check_complete("fwd", cyc);
`ifdef CACHE_LINE_MOVER_FWD_EN
    total++;
    if (fwd_pulses - p0 != 8) begin
      bad++;
      $display("FAIL fwd_pulses got=%0d want=8", fwd_pulses - p0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_clean();
    test_dirty();
    test_backpressure();
    test_gapped_fill();
    test_reset_mid_wb();
    test_forward();
    repeat (2) @(posedge main_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
